// File: rtl/muldiv_sequencer.sv
// RV32 M-extension iterative unit: shift-add multiplier and restoring divider behind a stall.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; divide stays iterative.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic [1:0]      dbg_state
);
  localparam int CW = $clog2(XLEN + 1);

  // Handshake: an op is taken only in IDLE when start is high with an M-op and no flush;
  // result_valid is a one-cycle strobe in DONE, where stall drops so the pipeline advances.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]     m_q, m_d;
  logic [2*XLEN-1:0]   p_q, p_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                result_valid_q, result_valid_d;

  logic                is_mop, accept, busy;
  logic [2:0]          op_in;
  logic                a_signed, b_signed, neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [XLEN:0]       mul_sum, div_trial;
  logic [2*XLEN-1:0]   mul_next, div_next;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0]   fast_prod;
`endif

  // p holds {high, low} of the product, or {remainder, quotient} while dividing.
  function automatic logic [XLEN-1:0] fixup(input logic [2:0] op, input logic neg,
                                            input logic neg_rem, input logic [2*XLEN-1:0] p);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   q, r;
    prod = neg ? -p : p;
    q    = neg ? -p[XLEN-1:0] : p[XLEN-1:0];
    r    = neg_rem ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
    if (op[2])               fixup = op[1] ? r : q;
    else if (op[1:0] == 2'b00) fixup = prod[XLEN-1:0];
    else                     fixup = prod[2*XLEN-1:XLEN];
  endfunction

  always_comb begin
    op_in    = alu_op[2:0];
    is_mop   = (alu_op[4:3] == 2'b01);
    busy     = (state_q == S_MUL) || (state_q == S_DIV);
    accept   = (state_q == S_IDLE) && start && is_mop && !flush;
    stall    = ((state_q == S_IDLE) && start && is_mop) || busy;
    a_signed = (op_in == 3'b001) || (op_in == 3'b010) || (op_in == 3'b100) || (op_in == 3'b110);
    b_signed = (op_in == 3'b001) || (op_in == 3'b100) || (op_in == 3'b110);
    neg_a    = a_signed && rs1_val[XLEN-1];
    neg_b    = b_signed && rs2_val[XLEN-1];
    mag_a    = neg_a ? -rs1_val : rs1_val;
    mag_b    = neg_b ? -rs2_val : rs2_val;
    div_zero = (rs2_val == '0);
    div_ovf  = !op_in[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

    mul_sum   = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, m_q} : '0);
    mul_next  = {mul_sum, p_q[XLEN-1:1]};
    div_trial = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]} - {1'b0, m_q};
    div_next  = div_trial[XLEN] ? {p_q[2*XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], p_q[XLEN-2:0], 1'b1};

    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    neg_d          = neg_q;
    neg_rem_d      = neg_rem_q;
    m_d            = m_q;
    p_d            = p_q;
    result_d       = result_q;
    result_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d      = op_in;
          neg_d     = neg_a ^ neg_b;
          neg_rem_d = neg_a;
          cnt_d     = CW'(XLEN);
          if (op_in[2]) begin
            if (div_zero) begin
              result_d       = op_in[1] ? rs1_val : '1;
              result_valid_d = 1'b1;
              state_d        = S_DONE;
            end else if (div_ovf) begin
              result_d       = op_in[1] ? '0 : rs1_val;
              result_valid_d = 1'b1;
              state_d        = S_DONE;
            end else begin
              m_d     = mag_b;
              p_d     = {{XLEN{1'b0}}, mag_a};
              state_d = S_DIV;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            result_d       = fixup(op_in, neg_a ^ neg_b, neg_a, fast_prod);
            result_valid_d = 1'b1;
            state_d        = S_DONE;
`else
            m_d     = mag_a;
            p_d     = {{XLEN{1'b0}}, mag_b};
            state_d = S_MUL;
`endif
          end
        end
      end
      S_MUL, S_DIV: begin
        p_d   = (state_q == S_MUL) ? mul_next : div_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d       = fixup(op_q, neg_q, neg_rem_q, p_d);
          result_valid_d = 1'b1;
          state_d        = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An aborted op must leave the previous result untouched and raise no strobe.
    if (flush) begin
      state_d        = S_IDLE;
      result_d       = result_q;
      result_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      op_q           <= '0;
      neg_q          <= 1'b0;
      neg_rem_q      <= 1'b0;
      m_q            <= '0;
      p_q            <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      neg_q          <= neg_d;
      neg_rem_q      <= neg_rem_d;
      m_q            <= m_d;
      p_q            <= p_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed M-op cases, flush/reset aborts, back-to-back ops and
// random ops compared against an arithmetic reference model.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [4:0]  alu_op;
  logic [31:0] rs1_val, rs2_val;
  logic        stall, result_valid;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  logic [31:0] exp_q[$];

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_op(alu_op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .flush(flush),
    .stall(stall), .result(result), .result_valid(result_valid),
    .dbg_state(dbg_state)
  );

  // Clock and strobe counter
  always #5 clk = ~clk;
  always @(negedge clk) if (result_valid === 1'b1) strobes++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic following the RISC-V M rules.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 33;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one M-op at the current cycle and follow it to its strobe; ends in the next cycle.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit hold);
    int n = 0;
    int stall_cnt = 0;
    int lat;
    exp_q.push_back(ref_result(op, a, b));
    lat = ref_lat(op, a, b);
    start = 1'b1; alu_op = {2'b01, op}; rs1_val = a; rs2_val = b;
    #1;
    while (result_valid !== 1'b1 && n < 100) begin
      if (stall === 1'b1) stall_cnt++;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      #1;
      n++;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " stall_cycles"}, stall_cnt, lat);
    chk({tag, " stall_in_done"}, {31'b0, stall}, 0);
    chk({tag, " result"}, result, exp_q.pop_front());
    tick();
    chk({tag, " strobe_one_cycle"}, {31'b0, result_valid}, 0);
  endtask

  initial begin
    int s0;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; flush = 1'b0; alu_op = '0; rs1_val = '0; rs2_val = '0;
    repeat (3) tick();
    chk("reset stall", {31'b0, stall}, 0);
    chk("reset result", result, 0);
    chk("reset result_valid", {31'b0, result_valid}, 0);
    chk("reset state", {30'b0, dbg_state}, 0);
    reset = 1'b0;
    tick();

    // Directed cases
    do_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    do_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op("MULHSU -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    do_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 1'b0);
    do_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 1'b0);
    do_op("DIVU by0", 3'd5, 32'h1234, 32'd0, 1'b0);
    do_op("REM by0", 3'd6, 32'h1234, 32'd0, 1'b0);
    do_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Non-M op must be ignored
    s0 = strobes;
    start = 1'b1; alu_op = 5'b00_100; rs1_val = 32'd9; rs2_val = 32'd3;
    #1;
    chk("nonM stall", {31'b0, stall}, 0);
    tick();
    start = 1'b0;
    chk("nonM state", {30'b0, dbg_state}, 0);
    repeat (3) tick();
    chk("nonM no strobe", strobes, s0);

    // Flush at C+10 aborts a divide, then a fresh MUL at C+12 completes
    s0 = strobes;
    start = 1'b1; alu_op = 5'b01_100; rs1_val = 32'd1000; rs2_val = 32'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush stall", {31'b0, stall}, 0);
    chk("flush result_valid", {31'b0, result_valid}, 0);
    chk("flush state", {30'b0, dbg_state}, 0);
    tick();
    do_op("MUL after flush", 3'd0, 32'd12345, 32'd678, 1'b0);
    repeat (3) tick();
    chk("flush strobe count", strobes, s0 + 1);

    // Reset at C+10 aborts and clears result
    s0 = strobes;
    start = 1'b1; alu_op = 5'b01_101; rs1_val = 32'd5000; rs2_val = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset abort stall", {31'b0, stall}, 0);
    chk("reset abort result", result, 0);
    chk("reset abort state", {30'b0, dbg_state}, 0);
    repeat (40) tick();
    chk("reset abort no strobe", strobes, s0);

    // Back-to-back with start held: each op accepted exactly once
    s0 = strobes;
    do_op("b2b DIVU", 3'd5, 32'd1000, 32'd9, 1'b1);
    do_op("b2b MULHU", 3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    start = 1'b0;
    repeat (40) tick();
    chk("b2b strobe count", strobes, s0 + 2);

    // Random ops with corner-biased divisors
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 15);
        3: rb = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: rb = $urandom;
      endcase
      do_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
